// File: rtl/hann_window_apply.sv
// 32-point Hann window applied to a framed stream of signed samples.
// Frame FSM assigns indices; a two-stage pipeline multiplies by a Q11 table.
module hann_window_apply #(
  parameter int unsigned DW    = 12,
  parameter int unsigned CW    = 12,
  parameter int unsigned SHIFT = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_data,
  output logic                 out_valid,
  output logic signed [DW-1:0] out_data,
  output logic [4:0]           out_index,
  output logic                 out_last,
  output logic                 busy,
  output logic                 sync_err
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic       accept;
  logic [4:0] acc_idx;

  logic                 s1_valid;
  logic signed [DW-1:0] s1_x;
  logic [CW-1:0]        s1_w;
  logic [4:0]           s1_idx;

  logic signed [DW+CW:0] prod;
  logic signed [DW+CW:0] prod_sh;
  logic                  unused_prod_hi;

  // Table is symmetric about k=16, so only w[0..16] is stored.
  function automatic logic [CW-1:0] coef(input logic [4:0] k);
    logic [4:0]  m;
    int unsigned v;
    m = (k > 5'd16) ? (5'd0 - k) : k;
    case (m)
      5'd1:    v = 20;
      5'd2:    v = 78;
      5'd3:    v = 173;
      5'd4:    v = 300;
      5'd5:    v = 455;
      5'd6:    v = 632;
      5'd7:    v = 824;
      5'd8:    v = 1024;
      5'd9:    v = 1224;
      5'd10:   v = 1416;
      5'd11:   v = 1593;
      5'd12:   v = 1748;
      5'd13:   v = 1875;
      5'd14:   v = 1970;
      5'd15:   v = 2028;
      5'd16:   v = 2048;
      default: v = 0;
    endcase
    return CW'(v);
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    acc_idx = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid && start) begin
          accept  = 1'b1;
          acc_idx = 5'd0;
          state_d = StRun;
          cnt_d   = 5'd1;
        end
      end
      StRun: begin
        // start is ignored here; a stray start only raises sync_err.
        if (in_valid) begin
          accept = 1'b1;
          if (cnt_q == 5'd31) begin
            state_d = StIdle;
            cnt_d   = 5'd0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= 5'd0;
      sync_err <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sync_err <= (state_q == StRun) && in_valid && start;
    end
  end

  assign busy = (state_q == StRun);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_w     <= '0;
      s1_idx   <= 5'd0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_x   <= in_data;
        s1_w   <= coef(acc_idx);
        s1_idx <= acc_idx;
      end
    end
  end

  // w <= 1.0 keeps |result| <= |x|, so truncating to DW bits never overflows.
  assign prod           = s1_x * $signed({1'b0, s1_w});
  assign prod_sh        = prod >>> SHIFT;
  assign unused_prod_hi = ^prod_sh[DW+CW:DW];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= 5'd0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data  <= prod_sh[DW-1:0];
        out_index <= s1_idx;
        out_last  <= (s1_idx == 5'd31);
      end
    end
  end

endmodule
